// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the team's synchronous FIFO and its read-side
//   stream adapter.
//
//   DATA_WIDTH_DEFAULT : default word width for FIFO and stream data
//   FIFO_READ_LATENCY  : cycles from pop strobe to valid read data
//   BUF_DEPTH          : entries in the read-side skid buffer
//   clog2()            : ceiling log2, usable in constant expressions
//   occ_t              : occupancy count of the skid buffer (0..BUF_DEPTH)
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;
    localparam int FIFO_READ_LATENCY  = 1;
    localparam int BUF_DEPTH          = 2;

    // Ceiling log2; clog2(1) returns 0, clog2(4) returns 2, clog2(5) returns 3.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    typedef logic [clog2(BUF_DEPTH + 1)-1:0] occ_t;

endpackage

// File: rtl/stream_buf2.sv
// -----------------------------------------------------------------------------
// stream_buf2
//   Two-entry register FIFO. entry0 is always the head, so the head output is
//   a plain register with no read mux behind it.
//
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high; clears both entries and occupancy
//   push       : write push_data at the tail this cycle
//   push_data  : word to write
//   pop        : drop the head this cycle (caller only pops when occ > 0)
//   head       : current head word
//   occ        : number of valid entries (0..2)
// -----------------------------------------------------------------------------
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;

    // NOTE: both entries are reset, not just occ, because entry0 drives the
    // stream data output directly and that output must read zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry0 <= '0;
            entry1 <= '0;
            occ    <= '0;
        end else begin
            // NOTE: non-blocking assignments let entry0 take the old entry1
            // while entry1 takes the new word on the same edge.
            unique case ({push, pop})
                2'b10: begin
                    if (occ == occ_t'(0)) entry0 <= push_data;
                    else                  entry1 <= push_data;
                    occ <= occ + occ_t'(1);
                end
                2'b01: begin
                    entry0 <= entry1;
                    occ    <= occ - occ_t'(1);
                end
                2'b11: begin
                    // Simultaneous push and pop: occupancy unchanged, the new
                    // word lands behind whatever survives the pop.
                    if (occ == occ_t'(2)) begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end else begin
                        entry0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = entry0;

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//   Read-side controller for the team's synchronous FIFO. Issues pops, absorbs
//   the FIFO's registered read latency in a two-entry skid buffer, and presents
//   the words as a valid/ready stream grouped into bursts of BURST_LEN beats.
//
//   clk           : rising-edge clock
//   reset         : asynchronous, active-high
//   enable        : gate for new FIFO reads; buffered/in-flight words still drain
//   fifo_empty    : FIFO empty flag
//   fifo_data_out : FIFO read data, valid the cycle after a pop
//   fifo_read_en  : FIFO pop strobe (combinational)
//   m_valid       : stream data valid
//   m_ready       : downstream accept
//   m_data        : stream data
//   m_last        : final beat of a burst
//   beat_idx      : beat position within the current burst
// -----------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int BURST_LEN  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         fifo_empty,
    input  logic [DATA_WIDTH-1:0]        fifo_data_out,
    output logic                         fifo_read_en,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic                         m_last,
    output logic [clog2(BURST_LEN)-1:0]  beat_idx
);

    localparam int BEAT_W = clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    occ_t                         occ;
    logic                         pop;
    logic                         inflight;
    logic [FIFO_READ_LATENCY-1:0] inflight_pipe;
    int                           pending;

    assign m_valid  = (occ != occ_t'(0));
    assign pop      = m_valid & m_ready;
    assign inflight = inflight_pipe[FIFO_READ_LATENCY-1];

    // Only pop the FIFO when the word is guaranteed a buffer slot on arrival:
    // words already buffered plus words in flight, less the one leaving now.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        fifo_read_en = 1'b0;
        pending      = int'(occ) + $countones(inflight_pipe) - int'(pop);
        if (enable && !fifo_empty && !reset && (pending < BUF_DEPTH))
            fifo_read_en = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_pipe <= '0;
            beat_idx      <= '0;
        end else begin
            inflight_pipe <= FIFO_READ_LATENCY'({inflight_pipe, fifo_read_en});
            // The beat counter tracks accepted beats only, so a burst stalled
            // by an empty FIFO or a low enable resumes where it left off.
            if (pop)
                beat_idx <= (beat_idx == LAST_BEAT) ? '0 : beat_idx + 1'b1;
        end
    end

    assign m_last = m_valid & (beat_idx == LAST_BEAT);

    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (fifo_data_out),
        .pop       (pop),
        .head      (m_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    localparam int DW = 16;
    localparam int BL = 4;
    localparam int BW = fifo_pkg::clog2(BL);

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_read_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [BW-1:0] beat_idx;

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_read_en  (fifo_read_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .beat_idx      (beat_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural FIFO with 1-cycle registered read --------
    logic [DW-1:0] fifo_mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops   = 0;
    int cyc    = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr        <= wr_ptr;
            pops          <= 0;
            fifo_data_out <= '0;
        end else if (fifo_read_en) begin
            fifo_data_out <= fifo_mem[rd_ptr % 1024];
            rd_ptr        <= rd_ptr + 1;
            pops          <= pops + 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model: words leave in push order ----------
    logic [DW-1:0] exp_q [$];
    int            acc = 0;
    logic [BW-1:0] log_beat [$];
    logic          log_last [$];
    int            log_cyc  [$];
    logic [DW-1:0] log_data [$];

    task automatic push_word(input logic [DW-1:0] w);
        fifo_mem[wr_ptr % 1024] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    task automatic clear_logs();
        log_beat.delete();
        log_last.delete();
        log_cyc.delete();
        log_data.delete();
    endtask

    // Monitor: samples mid-cycle; an accept happens at the next rising edge.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always @(negedge clk) begin
        logic          accept;
        logic [DW-1:0] exp_w;
        if (reset) begin
            acc        = 0;
            prev_stall = 1'b0;
        end else begin
            accept = m_valid & m_ready;
            if (fifo_read_en)
                check("pop_while_empty", 32'(fifo_empty), 32'd0);
            check("outstanding_le_2",
                  32'((pops + int'(fifo_read_en) - acc - int'(accept)) <= 2), 32'd1);
            if (!m_valid)
                check("last_while_idle", 32'(m_last), 32'd0);
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (accept) begin
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                check("beat_data", 32'(m_data), 32'(exp_w));
                check("beat_idx", 32'(beat_idx), 32'(acc % BL));
                check("beat_last", 32'(m_last), 32'((acc % BL) == BL - 1));
                log_beat.push_back(beat_idx);
                log_last.push_back(m_last);
                log_cyc.push_back(cyc);
                log_data.push_back(m_data);
                acc = acc + 1;
            end
            prev_stall = m_valid & !m_ready;
            prev_data  = m_data;
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        exp_q.delete();
        clear_logs();
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget, input string tag);
        int k = 0;
        while (acc < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check(tag, 32'(acc >= n), 32'd1);
    endtask

    // ---------------- directed sequence -----------------------------------
    logic          lat_re [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic          lat_v  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] lat_d  [6] = '{16'h0, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h0};
    logic [DW-1:0] words  [8];
    int            target;
    int            pushed;
    int            k;

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        #12;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_beat", 32'(beat_idx), 32'd0);
        check("rst_read_en", 32'(fifo_read_en), 32'd0);
        step();
        reset   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;

        // Latency: three preloaded words, cycle 0 is the first non-empty cycle.
        step();
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("lat_read_en_c%0d", c), 32'(fifo_read_en), 32'(lat_re[c]));
            check($sformatf("lat_valid_c%0d", c), 32'(m_valid), 32'(lat_v[c]));
            if (lat_v[c])
                check($sformatf("lat_data_c%0d", c), 32'(m_data), 32'(lat_d[c]));
        end

        // Asynchronous reset mid-burst, between clock edges.
        step();
        for (int i = 0; i < 6; i++) push_word(16'(16'h5000 + i));
        wait_acc(5, 40, "midrst_timeout");
        #2;
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(m_valid), 32'd0);
        check("midrst_last", 32'(m_last), 32'd0);
        check("midrst_read_en", 32'(fifo_read_en), 32'd0);
        check("midrst_beat", 32'(beat_idx), 32'd0);
        check("midrst_data", 32'(m_data), 32'd0);
        exp_q.delete();
        clear_logs();
        repeat (2) step();
        reset = 1'b0;

        // Burst marking: 8 back-to-back beats.
        step();
        clear_logs();
        for (int i = 0; i < 8; i++) push_word(16'($urandom));
        wait_acc(8, 40, "burst_timeout");
        for (int i = 0; i < 8 && i < log_cyc.size(); i++) begin
            check($sformatf("burst_beat_%0d", i), 32'(log_beat[i]), 32'(i % BL));
            check($sformatf("burst_last_%0d", i), 32'(log_last[i]), 32'((i % BL) == BL - 1));
            check($sformatf("burst_gap_%0d", i), 32'(log_cyc[i] - log_cyc[0]), 32'(i));
        end

        // Backpressure: 6 words, consumer stalled for 10 cycles.
        do_reset();
        m_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            words[i] = 16'($urandom);
            push_word(words[i]);
        end
        repeat (10) step();
        @(negedge clk);
        check("bp_pops", 32'(pops), 32'd2);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_data", 32'(m_data), 32'(words[0]));
        step();
        m_ready = 1'b1;
        wait_acc(6, 40, "bp_timeout");
        for (int i = 0; i < 6 && i < log_cyc.size(); i++) begin
            check($sformatf("bp_order_%0d", i), 32'(log_data[i]), 32'(words[i]));
            check($sformatf("bp_gap_%0d", i), 32'(log_cyc[i] - log_cyc[0]), 32'(i));
        end

        // Random backpressure and bursty FIFO fill over 200 words.
        target = acc + 200;
        pushed = 0;
        k      = 0;
        while (acc < target && k < 4000) begin
            step();
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < 200 && $urandom_range(0, 3) != 0) begin
                push_word(16'($urandom));
                pushed++;
            end
            k++;
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("rand_timeout", 32'(acc >= target), 32'd1);
        check("rand_leftover", 32'(exp_q.size()), 32'd0);

        // enable dropped while a read is in flight.
        do_reset();
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 4; i++) push_word(16'(16'hA000 + i));
        @(negedge clk);
        check("en_first_read", 32'(fifo_read_en), 32'd1);
        step();
        enable = 1'b0;
        @(negedge clk);
        check("en_off_read", 32'(fifo_read_en), 32'd0);
        repeat (6) step();
        @(negedge clk);
        check("en_off_pops", 32'(pops), 32'd1);
        check("en_off_delivered", 32'(acc), 32'd1);
        step();
        enable = 1'b1;
        @(negedge clk);
        check("en_resume_read", 32'(fifo_read_en), 32'd1);
        wait_acc(4, 30, "en_timeout");
        check("en_leftover", 32'(exp_q.size()), 32'd0);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
